// File: rtl/semaforo_pkg.sv
// Shared definitions for the intersection sequencer and its lamp drivers.
// State codes double as the debug code on the estado output.
// Lamp buses are one-hot {rojo, amarillo, verde}; all-zero means dark.
package semaforo_pkg;

  typedef enum logic [2:0] {
    ST_ALLROJO_A  = 3'd0,
    ST_VERDE_A    = 3'd1,
    ST_AMARILLO_A = 3'd2,
    ST_ALLROJO_B  = 3'd3,
    ST_VERDE_B    = 3'd4,
    ST_AMARILLO_B = 3'd5,
    ST_PEATON     = 3'd6,
    ST_BLINK      = 3'd7
  } estado_t;

  localparam logic [2:0] LUZ_ROJO     = 3'b100;
  localparam logic [2:0] LUZ_AMARILLO = 3'b010;
  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_OFF      = 3'b000;

  // Out-of-service pattern: amber when the blink phase is on, dark otherwise.
  function automatic logic [2:0] luz_blink(input logic on);
    return on ? LUZ_AMARILLO : LUZ_OFF;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Clock-enable prescaler: one-cycle tick every CLK_DIV clk cycles.
// Latency: first tick on the CLK_DIV-th cycle after reset deasserts.
// Backpressure: none; free-running in every state of the owner.
module divisor_tick #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Wrap to zero on the tick cycle, otherwise count up.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cruce_controlador.sv
// Two-road intersection plus pedestrian crossing sequencer with amber-blink mode.
// Latency: lamps follow the state register, changing the cycle after the deciding tick.
// Backpressure: none; on_off=0 forces BLINK next cycle, peaton_req is latched until served.
module cruce_controlador #(
  parameter int CLK_DIV    = 50_000_000,
  parameter int T_VERDE    = 20,
  parameter int T_AMARILLO = 3,
  parameter int T_ALLROJO  = 2,
  parameter int T_PEATON   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_off,
  input  logic       peaton_req,
  output logic [2:0] luz_a,
  output logic [2:0] luz_b,
  output logic       peaton_verde,
  output logic [2:0] estado
);

  import semaforo_pkg::*;

  localparam int T_MAX_VA = (T_VERDE > T_AMARILLO) ? T_VERDE : T_AMARILLO;
  localparam int T_MAX_RP = (T_ALLROJO > T_PEATON) ? T_ALLROJO : T_PEATON;
  localparam int T_MAX    = (T_MAX_VA > T_MAX_RP) ? T_MAX_VA : T_MAX_RP;
  localparam int TW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] LAST_VERDE    = TW'(T_VERDE - 1);
  localparam logic [TW-1:0] LAST_AMARILLO = TW'(T_AMARILLO - 1);
  localparam logic [TW-1:0] LAST_ALLROJO  = TW'(T_ALLROJO - 1);
  localparam logic [TW-1:0] LAST_PEATON   = TW'(T_PEATON - 1);

  estado_t       state_q, state_d;
  estado_t       phase_next;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] last_cnt;
  logic          pend_q, pend_d;
  logic          blink_q, blink_d;
  logic          tick;
  logic          phase_end;

  divisor_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_divisor_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Length (as final timer value) and successor of the current phase.
  always_comb begin
    last_cnt   = '0;
    phase_next = ST_ALLROJO_A;
    case (state_q)
      ST_ALLROJO_A: begin
        last_cnt   = LAST_ALLROJO;
        phase_next = ST_VERDE_A;
      end
      ST_VERDE_A: begin
        last_cnt   = LAST_VERDE;
        phase_next = ST_AMARILLO_A;
      end
      ST_AMARILLO_A: begin
        last_cnt   = LAST_AMARILLO;
        phase_next = ST_ALLROJO_B;
      end
      ST_ALLROJO_B: begin
        last_cnt   = LAST_ALLROJO;
        phase_next = ST_VERDE_B;
      end
      ST_VERDE_B: begin
        last_cnt   = LAST_VERDE;
        phase_next = ST_AMARILLO_B;
      end
      ST_AMARILLO_B: begin
        // Registered pend only: a request in this very cycle waits a round.
        last_cnt   = LAST_AMARILLO;
        phase_next = pend_q ? ST_PEATON : ST_ALLROJO_A;
      end
      ST_PEATON: begin
        last_cnt   = LAST_PEATON;
        phase_next = ST_ALLROJO_A;
      end
      default: begin
        last_cnt   = '0;
        phase_next = ST_ALLROJO_A;
      end
    endcase
  end

  assign phase_end = tick && (timer_q == last_cnt);

  // Next-state: blink mode overrides everything; otherwise step on phase end.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    blink_d = blink_q;
    if (!on_off) begin
      state_d = ST_BLINK;
      if (state_q != ST_BLINK) begin
        timer_d = '0;
        pend_d  = 1'b0;
        blink_d = 1'b1;
      end else if (tick) begin
        blink_d = ~blink_q;
      end
    end else if (state_q == ST_BLINK) begin
      // Safe restart: all red with a fresh phase timer.
      state_d = ST_ALLROJO_A;
      timer_d = '0;
      blink_d = 1'b0;
    end else begin
      if (peaton_req && (state_q != ST_PEATON)) begin
        pend_d = 1'b1;
      end
      if (phase_end) begin
        state_d = phase_next;
        timer_d = '0;
        if (phase_next == ST_PEATON) begin
          pend_d = 1'b0;
        end
      end else if (tick) begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ALLROJO_A;
      timer_q <= '0;
      pend_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
    end
  end

  // Lamp decode from registered state only; default is both roads red.
  always_comb begin
    luz_a        = LUZ_ROJO;
    luz_b        = LUZ_ROJO;
    peaton_verde = 1'b0;
    case (state_q)
      ST_VERDE_A:    luz_a = LUZ_VERDE;
      ST_AMARILLO_A: luz_a = LUZ_AMARILLO;
      ST_VERDE_B:    luz_b = LUZ_VERDE;
      ST_AMARILLO_B: luz_b = LUZ_AMARILLO;
      ST_PEATON:     peaton_verde = 1'b1;
      ST_BLINK: begin
        luz_a = luz_blink(blink_q);
        luz_b = luz_blink(blink_q);
      end
      default: ;
    endcase
  end

  assign estado = state_q;

endmodule

// File: tb/tb_cruce_controlador.sv
// Scoreboard bench for cruce_controlador with a shortened timing set.
// Stimulus pushes the expected outputs of each directed cycle; a negedge monitor pops and compares.
// A random phase checks lamp safety invariants every cycle.
module tb_cruce_controlador;

  logic       clk = 1'b0;
  logic       reset;
  logic       on_off;
  logic       peaton_req;
  logic [2:0] luz_a;
  logic [2:0] luz_b;
  logic       peaton_verde;
  logic [2:0] estado;

  always #5 clk = ~clk;

  cruce_controlador #(
    .CLK_DIV   (4),
    .T_VERDE   (3),
    .T_AMARILLO(2),
    .T_ALLROJO (1),
    .T_PEATON  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .on_off      (on_off),
    .peaton_req  (peaton_req),
    .luz_a       (luz_a),
    .luz_b       (luz_b),
    .peaton_verde(peaton_verde),
    .estado      (estado)
  );

  typedef struct {
    int         tid;
    logic [2:0] est;
    logic [2:0] la;
    logic [2:0] lb;
    logic       pv;
  } exp_t;

  exp_t exp_q[$];
  int   tid     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   inv_en  = 1'b0;
  bit   done    = 1'b0;
  bit   drained = 1'b0;

  // Hand table of lamp values per state code.
  function automatic exp_t mk(input int st, input bit bl);
    exp_t e;
    e.tid = tid;
    e.est = 3'(st);
    e.la  = 3'b100;
    e.lb  = 3'b100;
    e.pv  = 1'b0;
    case (st)
      1: e.la = 3'b001;
      2: e.la = 3'b010;
      4: e.lb = 3'b001;
      5: e.lb = 3'b010;
      6: e.pv = 1'b1;
      7: begin
        e.la = bl ? 3'b010 : 3'b000;
        e.lb = e.la;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Phase lengths in clk cycles: ticks * CLK_DIV.
  function automatic int dur(input int st);
    case (st)
      0, 3:    return 4;
      1, 4:    return 12;
      default: return 8;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n cycles expected in state st; peaton_req high for indices rlo..rhi.
  task automatic phase(input int st, input int n, input bit on, input bit bl,
                       input int rlo, input int rhi);
    for (int i = 0; i < n; i++) begin
      on_off     = on;
      peaton_req = (i >= rlo) && (i <= rhi);
      exp_q.push_back(mk(st, bl));
      step();
    end
    peaton_req = 1'b0;
  endtask

  task automatic round(input bit ped, input int rph, input int rlo, input int rhi);
    for (int p = 0; p < 7; p++) begin
      if (p < 6 || ped) begin
        phase(p, dur(p), 1'b1, 1'b0, (p == rph) ? rlo : -1, (p == rph) ? rhi : -1);
      end
    end
  endtask

  // Monitor: scoreboard compare plus safety invariants.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (estado !== e.est || luz_a !== e.la || luz_b !== e.lb || peaton_verde !== e.pv) begin
        errors++;
        $display("FAIL seq t%0d cyc%0d: got estado=%0d luz_a=%b luz_b=%b walk=%b, want estado=%0d luz_a=%b luz_b=%b walk=%b",
                 e.tid, cyc, estado, luz_a, luz_b, peaton_verde, e.est, e.la, e.lb, e.pv);
      end
    end
    if (inv_en) begin
      checks++;
      if (estado == 3'd7) begin
        ok = (luz_a == luz_b) && (luz_a == 3'b010 || luz_a == 3'b000) && !peaton_verde;
      end else begin
        ok = (luz_a == 3'b100 || luz_b == 3'b100) &&
             ($countones(luz_a) == 1) && ($countones(luz_b) == 1) &&
             (!peaton_verde || (luz_a == 3'b100 && luz_b == 3'b100));
      end
      if (!ok) begin
        errors++;
        $display("FAIL invariant cyc%0d: estado=%0d luz_a=%b luz_b=%b walk=%b",
                 cyc, estado, luz_a, luz_b, peaton_verde);
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
    end
  end

  initial begin
    reset      = 1'b1;
    on_off     = 1'b1;
    peaton_req = 1'b0;
    step();
    inv_en = 1'b1;

    // Reset values held while reset is high.
    phase(0, 2, 1'b1, 1'b0, -1, -1);
    reset = 1'b0;

    // 1: plain cycle, no requests.
    tid = 1;
    round(1'b0, -1, -1, -1);

    // 2: one-cycle request in VERDE_A is served once, then skipped.
    tid = 2;
    round(1'b1, 1, 5, 5);
    round(1'b0, -1, -1, -1);

    // 3: request in the AMARILLO_B exit cycle waits a round; request held
    //    through PEATON does not re-arm.
    tid = 3;
    round(1'b0, 5, 7, 7);
    round(1'b1, 6, 0, 7);
    round(1'b0, -1, -1, -1);

    // 4: blink mode entered mid VERDE_B; pending request discarded.
    tid = 4;
    phase(0, 4, 1'b1, 1'b0, 1, 1);
    phase(1, 12, 1'b1, 1'b0, -1, -1);
    phase(2, 8, 1'b1, 1'b0, -1, -1);
    phase(3, 4, 1'b1, 1'b0, -1, -1);
    phase(4, 3, 1'b1, 1'b0, -1, -1);
    phase(4, 1, 1'b0, 1'b0, -1, -1);
    phase(7, 4, 1'b0, 1'b1, -1, -1);
    phase(7, 4, 1'b0, 1'b0, -1, -1);
    phase(7, 3, 1'b0, 1'b1, -1, -1);
    phase(7, 1, 1'b1, 1'b1, -1, -1);
    round(1'b0, -1, -1, -1);

    // 5: one-cycle reset in AMARILLO_A restarts state and prescaler.
    tid = 5;
    phase(0, 4, 1'b1, 1'b0, -1, -1);
    phase(1, 12, 1'b1, 1'b0, -1, -1);
    phase(2, 1, 1'b1, 1'b0, -1, -1);
    reset = 1'b1;
    phase(2, 1, 1'b1, 1'b0, -1, -1);
    reset = 1'b0;
    round(1'b0, -1, -1, -1);

    // 6: random stream, invariants only.
    tid = 6;
    for (int i = 0; i < 10000; i++) begin
      reset      = ($urandom_range(99) == 0);
      on_off     = ($urandom_range(19) != 0);
      peaton_req = ($urandom_range(9) == 0);
      step();
    end
    reset      = 1'b0;
    on_off     = 1'b1;
    peaton_req = 1'b0;

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cruce_controlador.md
Name: cruce_controlador

Overview:
Sequences a two-road intersection (road A, road B) plus a pedestrian crossing. Drives one 3-bit lamp bus per road and a pedestrian "walk" lamp. All phase durations are counted in ticks from an internal clock-enable prescaler. This is the top-level sequencer above the per-lamp semaphore drivers. It also provides an out-of-service amber-blink mode selected by on_off.

Parameters:
CLK_DIV, 50_000_000, clk cycles per tick (1 s at 50 MHz); must be >= 2
T_VERDE, 20, ticks spent in each green phase
T_AMARILLO, 3, ticks spent in each amber phase
T_ALLROJO, 2, ticks of all-red clearance before each green
T_PEATON, 10, ticks of pedestrian walk phase

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
on_off  in  1  1 = normal cycling; 0 = amber-blink mode
peaton_req  in  1  pedestrian button, level, already synchronised/debounced
luz_a  out  3  road A lamps, one-hot {rojo,amarillo,verde}: 100 red, 010 amber, 001 green, 000 dark
luz_b  out  3  road B lamps, same encoding
peaton_verde  out  1  pedestrian walk lamp
estado  out  3  current state code, for debug/LEDs

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Prescaler: counter runs 0..CLK_DIV-1. tick=1 for the one cycle where counter==CLK_DIV-1, then the counter wraps to 0. It runs in all states. Reset clears it, so the first tick comes on the CLK_DIV-th cycle after reset deasserts.
- Phase timer: counts ticks inside a state. Cleared to 0 on every state change, on reset, and on entry to or exit from BLINK.
- A state of duration T exits on the tick where timer==T-1, so each state lasts exactly T ticks.
- States and codes, with outputs (luz_a / luz_b / peaton_verde):
  - ALLROJO_A (0): 100 / 100 / 0
  - VERDE_A (1): 001 / 100 / 0
  - AMARILLO_A (2): 010 / 100 / 0
  - ALLROJO_B (3): 100 / 100 / 0
  - VERDE_B (4): 100 / 001 / 0
  - AMARILLO_B (5): 100 / 010 / 0
  - PEATON (6): 100 / 100 / 1
  - BLINK (7): {0,blink,0} on both roads / 0
- Transitions:
  - ALLROJO_A -> VERDE_A -> AMARILLO_A -> ALLROJO_B -> VERDE_B -> AMARILLO_B.
  - AMARILLO_B -> PEATON if pend==1, else -> ALLROJO_A.
  - PEATON -> ALLROJO_A.
- Pedestrian latch pend:
  - Set on any cycle with peaton_req==1, in every state except PEATON and BLINK.
  - Cleared on entry to PEATON, on reset, and on entry to BLINK.
  - The AMARILLO_B exit decision uses the registered pend. A request asserted in the exit cycle itself is held and served on the next round.
- on_off==0: the next cycle is BLINK from any state, regardless of tick. Takes priority over every transition except reset.
- blink register: loads 1 on BLINK entry, toggles on each tick while in BLINK.
- on_off returning to 1: the next cycle is ALLROJO_A with timer=0. This is the safe restart.
- Outputs are a pure decode of the state register (and blink), so lamps change in the cycle after the deciding tick. No combinational path from inputs to outputs.
- Reset values: state=ALLROJO_A, luz_a=luz_b=100, peaton_verde=0, estado=0, pend=0, blink=0, all counters 0.
- Reset asserted mid-phase: the next cycle returns to these values.
- Invariant: luz_a and luz_b are never both non-red at once, and peaton_verde=1 only while both roads are red.
- Widths: timer and prescaler widths come from $clog2 of the largest T and of CLK_DIV.

Decomposition:
- Package semaforo_pkg:
  - state enum (codes 0-7 as above)
  - lamp constants LUZ_ROJO=3'b100, LUZ_AMARILLO=3'b010, LUZ_VERDE=3'b001, LUZ_OFF=3'b000
- Sub-module divisor_tick(clk, reset, tick), parameter CLK_DIV. It is reused by other timed blocks.

Test Plan:
For all scenarios use CLK_DIV=4, T_VERDE=3, T_AMARILLO=2, T_ALLROJO=1, T_PEATON=2.

1. Reset, on_off=1, no requests.
   - ALLROJO_A lasts 4 cycles (first tick at cycle 4).
   - VERDE_A lasts 12 cycles, AMARILLO_A 8, ALLROJO_B 4, VERDE_B 12, AMARILLO_B 8, then back to ALLROJO_A.
   - Check luz_a/luz_b values in every state.
2. Pulse peaton_req for 1 cycle during VERDE_A.
   - After AMARILLO_B: PEATON for 8 cycles with peaton_verde=1 and both roads 100, then ALLROJO_A.
   - The next round skips PEATON.
3. peaton_req held high through PEATON.
   - pend is not re-armed during PEATON.
   - Any request appearing after PEATON is served one round later.
4. Drop on_off to 0 mid VERDE_B.
   - Next cycle estado=7, luz_a=luz_b=010.
   - Lamps alternate 010/000 every 4 cycles.
   - Raise on_off: next cycle ALLROJO_A, and pend is 0.
5. Assert reset for 1 cycle mid AMARILLO_A.
   - Next cycle estado=0, both roads 100, prescaler restarts: first tick 4 cycles after reset deasserts.
6. Run a constrained-random on_off/peaton_req/reset stream for 10k cycles.
   - Assert the invariant (never both roads non-red; walk lamp only with both red) and that lamp buses are always one-hot or zero.
